// File: rtl/seg_scan_arbiter.sv
// ============================================================================
// Module      : seg_scan_arbiter
// Description : Scans an 8-digit seven-segment display and arbitrates it
//               between hold-timed CPU writes and the switch echo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_arbiter #(
    parameter int DIV_MAX     = 50000,
    parameter int HOLD_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sw,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_data,
    input  logic [7:0]  cpu_blank,
    input  logic        cpu_rel,
    output logic        owner,
    output logic        frame_end,
    output logic [7:0]  an,
    output logic [7:0]  seg,
    output logic [7:0]  seg1
);

    localparam int c_DIV_W  = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
    localparam int c_HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(DIV_MAX - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_FRAMES);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    localparam logic [0:0] c_ST_SW  = 1'b0;
    localparam logic [0:0] c_ST_CPU = 1'b1;

    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [2:0]          r_idx;
    logic                r_frame_end;
    logic [7:0]          r_an;
    logic [7:0]          r_seg;
    logic [7:0]          r_seg1;
    logic [31:0]         r_snap;
    logic [7:0]          r_snap_blank;
    logic [0:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [31:0]         r_cpu_data;
    logic [7:0]          r_cpu_blank;

    logic                w_tick;
    logic [2:0]          w_idx_nxt;
    logic [31:0]         w_src;
    logic [7:0]          w_src_blank;
    logic [31:0]         w_snap_nxt;
    logic [7:0]          w_snap_blank_nxt;
    logic [3:0]          w_nib;
    logic [7:0]          w_digit;
    logic [0:0]          w_state_nxt;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_latch;

    function automatic logic [7:0] f_enc(input logic [3:0] nib);
        case (nib)
            4'h0: f_enc = 8'hFC;
            4'h1: f_enc = 8'h60;
            4'h2: f_enc = 8'hDA;
            4'h3: f_enc = 8'hF2;
            4'h4: f_enc = 8'h66;
            4'h5: f_enc = 8'hB6;
            4'h6: f_enc = 8'hBE;
            4'h7: f_enc = 8'hE0;
            4'h8: f_enc = 8'hFE;
            4'h9: f_enc = 8'hF6;
            4'hA: f_enc = 8'hEE;
            4'hB: f_enc = 8'h3E;
            4'hC: f_enc = 8'h9C;
            4'hD: f_enc = 8'h7A;
            4'hE: f_enc = 8'h9E;
            default: f_enc = 8'h8E;
        endcase
    endfunction

    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_idx_nxt   = r_idx + 3'd1;
    assign w_src       = (r_state == c_ST_CPU) ? r_cpu_data : {{16{sw[15]}}, sw};
    assign w_src_blank = (r_state == c_ST_CPU) ? r_cpu_blank : 8'h00;

    // The digit-0 slot already shows the freshly captured frame.
    assign w_snap_nxt       = (w_idx_nxt == 3'd0) ? w_src : r_snap;
    assign w_snap_blank_nxt = (w_idx_nxt == 3'd0) ? w_src_blank : r_snap_blank;
    assign w_nib            = w_snap_nxt[{w_idx_nxt, 2'b00} +: 4];
    assign w_digit          = w_snap_blank_nxt[w_idx_nxt] ? 8'h00 : f_enc(w_nib);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_idx        <= 3'd0;
            r_frame_end  <= 1'b0;
            r_an         <= 8'h01;
            r_seg        <= 8'h00;
            r_seg1       <= 8'h00;
            r_snap       <= 32'h0;
            r_snap_blank <= 8'h00;
        end else begin
            r_div_cnt   <= w_tick ? '0 : r_div_cnt + 1'b1;
            r_frame_end <= 1'b0;
            if (w_tick) begin
                r_idx        <= w_idx_nxt;
                r_an         <= 8'h01 << w_idx_nxt;
                r_frame_end  <= (r_idx == 3'd7);
                r_snap       <= w_snap_nxt;
                r_snap_blank <= w_snap_blank_nxt;
                r_seg        <= w_idx_nxt[2] ? w_digit : 8'h00;
                r_seg1       <= w_idx_nxt[2] ? 8'h00 : w_digit;
            end
        end
    end

    // Ownership: a write always wins over release and over hold expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_latch     = 1'b0;
        case (r_state)
            c_ST_SW: begin
                if (cpu_wr) begin
                    w_state_nxt = c_ST_CPU;
                    w_hold_nxt  = c_HOLD_INIT;
                    w_latch     = 1'b1;
                end
            end
            c_ST_CPU: begin
                if (cpu_wr) begin
                    w_hold_nxt = c_HOLD_INIT;
                    w_latch    = 1'b1;
                end else if (cpu_rel) begin
                    w_state_nxt = c_ST_SW;
                end else if (r_frame_end) begin
                    if (r_hold == c_HOLD_ONE) begin
                        w_state_nxt = c_ST_SW;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold - 1'b1;
                    end
                end
            end
            default: w_state_nxt = c_ST_SW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_SW;
            r_hold      <= '0;
            r_cpu_data  <= 32'h0;
            r_cpu_blank <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            if (w_latch) begin
                r_cpu_data  <= cpu_data;
                r_cpu_blank <= cpu_blank;
            end
        end
    end

    assign owner     = r_state[0];
    assign frame_end = r_frame_end;
    assign an        = r_an;
    assign seg       = r_seg;
    assign seg1      = r_seg1;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_arbiter.sv
// ============================================================================
// Module      : tb_seg_scan_arbiter
// Description : Scoreboard bench for seg_scan_arbiter against a digit-level
//               reference model, directed scenarios followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_arbiter;

    localparam int c_DIV  = 4;
    localparam int c_HOLD = 2;

    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic        cpu_wr;
    logic [31:0] cpu_data;
    logic [7:0]  cpu_blank;
    logic        cpu_rel;
    logic        owner;
    logic        frame_end;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [7:0]  seg1;

    seg_scan_arbiter #(
        .DIV_MAX     (c_DIV),
        .HOLD_FRAMES (c_HOLD)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .cpu_wr    (cpu_wr),
        .cpu_data  (cpu_data),
        .cpu_blank (cpu_blank),
        .cpu_rel   (cpu_rel),
        .owner     (owner),
        .frame_end (frame_end),
        .an        (an),
        .seg       (seg),
        .seg1      (seg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic [7:0] seg1;
        logic       fe;
        logic       owner;
    } exp_t;

    exp_t q_exp[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state, tracked per clock at digit / frame granularity.
    logic [7:0] enc_tab [16];
    int         m_div, m_idx, m_hold;
    logic       m_fe, m_owner;
    logic [7:0] m_an, m_seg, m_seg1, m_cblank, m_snap_mask;
    logic [31:0] m_cdata, m_snap;
    logic [15:0] cur_sw;

    initial begin
        enc_tab[0]  = 8'hFC; enc_tab[1]  = 8'h60; enc_tab[2]  = 8'hDA; enc_tab[3]  = 8'hF2;
        enc_tab[4]  = 8'h66; enc_tab[5]  = 8'hB6; enc_tab[6]  = 8'hBE; enc_tab[7]  = 8'hE0;
        enc_tab[8]  = 8'hFE; enc_tab[9]  = 8'hF6; enc_tab[10] = 8'hEE; enc_tab[11] = 8'h3E;
        enc_tab[12] = 8'h9C; enc_tab[13] = 8'h7A; enc_tab[14] = 8'h9E; enc_tab[15] = 8'h8E;
    end

    task automatic model_reset();
        m_div = 0; m_idx = 0; m_hold = 0; m_fe = 1'b0; m_owner = 1'b0;
        m_an = 8'h01; m_seg = 8'h00; m_seg1 = 8'h00;
        m_cdata = 32'h0; m_cblank = 8'h00; m_snap = 32'h0; m_snap_mask = 8'h00;
    endtask

    task automatic step(input logic i_rst, input logic [15:0] i_sw, input logic i_wr,
                        input logic [31:0] i_data, input logic [7:0] i_blank, input logic i_rel);
        logic        tick, old_owner, old_fe;
        logic [31:0] src;
        logic [7:0]  src_mask, digit;
        int          nidx, old_hold;
        exp_t        e;
        @(negedge clk);
        rst = i_rst; sw = i_sw; cpu_wr = i_wr; cpu_data = i_data;
        cpu_blank = i_blank; cpu_rel = i_rel;
        if (i_rst) begin
            model_reset();
        end else begin
            old_owner = m_owner;
            old_fe    = m_fe;
            old_hold  = m_hold;
            src       = old_owner ? m_cdata : {{16{i_sw[15]}}, i_sw};
            src_mask  = old_owner ? m_cblank : 8'h00;
            tick      = (m_div == c_DIV - 1);
            m_div     = tick ? 0 : m_div + 1;
            m_fe      = 1'b0;
            if (tick) begin
                nidx  = (m_idx + 1) % 8;
                m_fe  = (m_idx == 7);
                m_idx = nidx;
                if (nidx == 0) begin
                    m_snap      = src;
                    m_snap_mask = src_mask;
                end
                digit  = m_snap_mask[nidx] ? 8'h00 : enc_tab[(m_snap >> (4 * nidx)) & 32'hF];
                m_an   = 8'h01 << nidx;
                m_seg  = (nidx >= 4) ? digit : 8'h00;
                m_seg1 = (nidx >= 4) ? 8'h00 : digit;
            end
            if (i_wr) begin
                m_owner = 1'b1; m_hold = c_HOLD; m_cdata = i_data; m_cblank = i_blank;
            end else if (old_owner) begin
                if (i_rel) m_owner = 1'b0;
                else if (old_fe) begin
                    if (old_hold == 1) m_owner = 1'b0;
                    m_hold = old_hold - 1;
                end
            end
        end
        e.an = m_an; e.seg = m_seg; e.seg1 = m_seg1; e.fe = m_fe; e.owner = m_owner;
        q_exp.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, cur_sw, 1'b0, $urandom, 8'($urandom), 1'b0);
    endtask

    // Monitor: every clock edge the DUT presents one display state.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                n_tests++;
                if ({an, seg, seg1, frame_end, owner} !== e) begin
                    n_fail++;
                    $display("FAIL display @%0t: got an=%h seg=%h seg1=%h fe=%b owner=%b, want an=%h seg=%h seg1=%h fe=%b owner=%b",
                             $time, an, seg, seg1, frame_end, owner, e.an, e.seg, e.seg1, e.fe, e.owner);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; sw = 16'h0; cpu_wr = 1'b0; cpu_data = 32'h0; cpu_blank = 8'h0; cpu_rel = 1'b0;
        model_reset();
        cur_sw = 16'h1234;
        step(1'b1, cur_sw, 1'b0, 32'h0, 8'h0, 1'b0);
        step(1'b1, cur_sw, 1'b0, 32'h0, 8'h0, 1'b0);
        idle(70);
        cur_sw = 16'h8001;
        idle(40);
        step(1'b0, cur_sw, 1'b1, 32'hDEADBEEF, 8'h00, 1'b0);
        idle(120);
        step(1'b0, cur_sw, 1'b1, 32'h13579BDF, 8'h0F, 1'b0);
        idle(40);
        step(1'b0, cur_sw, 1'b1, 32'h2468ACE0, 8'hA0, 1'b1);
        idle(45);
        step(1'b1, cur_sw, 1'b0, 32'h0, 8'h0, 1'b0);
        cur_sw = 16'h7C3A;
        idle(40);
        step(1'b0, cur_sw, 1'b0, 32'h0, 8'h0, 1'b1);
        idle(10);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) cur_sw = 16'($urandom);
            step(($urandom_range(0, 299) == 0), cur_sw, ($urandom_range(0, 39) == 0),
                 $urandom, 8'($urandom), ($urandom_range(0, 59) == 0));
        end
        idle(2);
        repeat (3) @(posedge clk);
        #2;
        n_tests++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", q_exp.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
